// File: rtl/descrambler_pkg.sv
// Shared constants and types for the PIPE lane descrambler: LFSR polynomials,
// special symbol codes, sync-header encodings and PIPEWIDTH decoding.
package descrambler_pkg;

  localparam int DATA_W     = 32;
  localparam int LANE_BYTES = DATA_W / 8;

  // Galois feedback masks: X^16+X^5+X^4+X^3+1 and X^23+X^21+X^16+X^8+X^5+X^2+1
  localparam logic [15:0] LFSR16_TAPS = 16'h0039;
  localparam logic [15:0] LFSR16_SEED = 16'hFFFF;
  localparam logic [22:0] LFSR23_TAPS = 23'h210125;

  localparam logic [7:0] COM_CODE = 8'hBC;
  localparam logic [7:0] SKP_CODE = 8'h1C;
  localparam logic [7:0] EIEOS_B0 = 8'h00;
  localparam logic [7:0] EIEOS_B1 = 8'hFF;

  typedef enum logic [1:0] {
    SH_8B10B   = 2'b00,
    SH_DATA    = 2'b01,
    SH_OS      = 2'b10,
    SH_INVALID = 2'b11
  } sync_hdr_e;

  localparam logic [5:0] PW_8  = 6'd8;
  localparam logic [5:0] PW_16 = 6'd16;
  localparam logic [5:0] PW_32 = 6'd32;

  function automatic logic [LANE_BYTES-1:0] width_to_byte_en(input logic [5:0] w);
    case (w)
      PW_8:    return 4'b0001;
      PW_16:   return 4'b0011;
      PW_32:   return 4'b1111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/descrambler_lfsr_byte_step.sv
// One byte position of the descrambler chain: advances the active LFSR by one
// byte and produces the (de)scrambled output byte. Purely combinational.
module lfsr_byte_step
  import descrambler_pkg::*;
(
  input  logic        en,
  input  sync_hdr_e   mode,
  input  logic [15:0] lfsr16_in,
  input  logic [22:0] lfsr23_in,
  input  logic [7:0]  data_in,
  input  logic        k_in,
  output logic [15:0] lfsr16_out,
  output logic [22:0] lfsr23_out,
  output logic [7:0]  data_out
);

  function automatic logic [15:0] adv16(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = {t[14:0], 1'b0} ^ (t[15] ? LFSR16_TAPS : 16'h0000);
    return t;
  endfunction

  function automatic logic [7:0] key16(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  k;
    t = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = t[15];
      t    = {t[14:0], 1'b0} ^ (t[15] ? LFSR16_TAPS : 16'h0000);
    end
    return k;
  endfunction

  function automatic logic [22:0] adv23(input logic [22:0] s);
    logic [22:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = {t[21:0], 1'b0} ^ (t[22] ? LFSR23_TAPS : 23'h000000);
    return t;
  endfunction

  function automatic logic [7:0] key23(input logic [22:0] s);
    logic [22:0] t;
    logic [7:0]  k;
    t = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = t[22];
      t    = {t[21:0], 1'b0} ^ (t[22] ? LFSR23_TAPS : 23'h000000);
    end
    return k;
  endfunction

  logic is_com;
  logic is_skp;

  assign is_com = k_in && (data_in == COM_CODE);
  assign is_skp = k_in && (data_in == SKP_CODE);

  always_comb begin
    lfsr16_out = lfsr16_in;
    lfsr23_out = lfsr23_in;
    data_out   = 8'h00;
    if (en) begin
      data_out = data_in;
      case (mode)
        SH_8B10B: begin
          // COM leaves the LFSR at all-ones so the next byte uses the seed directly
          if (is_com) begin
            lfsr16_out = LFSR16_SEED;
          end else if (!is_skp) begin
            lfsr16_out = adv16(lfsr16_in);
            if (!k_in) data_out = data_in ^ key16(lfsr16_in);
          end
        end
        SH_DATA: begin
          lfsr23_out = adv23(lfsr23_in);
          data_out   = data_in ^ key23(lfsr23_in);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/descrambler.sv
// Per-lane PIPE descrambler for 8b/10b and 128b/130b encodings; four chained
// byte steps per cycle, registered outputs with one cycle of latency.
module descrambler
  import descrambler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              turnOff,
  input  logic              PIPEDataValid,
  input  logic [5:0]        PIPEWIDTH,
  input  logic [1:0]        PIPESyncHeader,
  input  logic [23:0]       seedValue,
  input  logic [DATA_W-1:0] PIPEData,
  input  logic [3:0]        PIPEDataK,
  output logic              descramblerDataValid,
  output logic [DATA_W-1:0] descramblerData,
  output logic [3:0]        descramblerDataK,
  output logic [1:0]        descramblerSyncHeader
);

  sync_hdr_e             mode;
  logic [LANE_BYTES-1:0] byte_en;
  logic [15:0]           lfsr16_r;
  logic [22:0]           lfsr23_r;
  logic                  seed_pend_r;
  logic [22:0]           lfsr23_cur;
  logic [15:0]           lfsr16_end;
  logic [22:0]           lfsr23_end;
  logic [DATA_W-1:0]     data_comb;
  logic                  eieos;
  logic                  unused_seed_msb;

  logic                  vld_p1;
  logic [DATA_W-1:0]     data_p1;
  logic [3:0]            k_p1;
  logic [1:0]            hdr_p1;

  assign mode            = sync_hdr_e'(PIPESyncHeader);
  assign byte_en         = width_to_byte_en(PIPEWIDTH);
  assign unused_seed_msb = seedValue[23];

  // Until the first valid cycle after reset the 23-bit LFSR tracks the live seed
  assign lfsr23_cur = seed_pend_r ? seedValue[22:0] : lfsr23_r;

  for (genvar i = 0; i < LANE_BYTES; i++) begin : g_byte
    logic [15:0] l16_in;
    logic [15:0] l16_out;
    logic [22:0] l23_in;
    logic [22:0] l23_out;
    logic [7:0]  step_byte;

    if (i == 0) begin : g_first
      assign l16_in = lfsr16_r;
      assign l23_in = lfsr23_cur;
    end else begin : g_next
      assign l16_in = g_byte[i-1].l16_out;
      assign l23_in = g_byte[i-1].l23_out;
    end

    lfsr_byte_step u_step (
      .en         (byte_en[i]),
      .mode       (mode),
      .lfsr16_in  (l16_in),
      .lfsr23_in  (l23_in),
      .data_in    (PIPEData[8*i +: 8]),
      .k_in       (PIPEDataK[i]),
      .lfsr16_out (l16_out),
      .lfsr23_out (l23_out),
      .data_out   (step_byte)
    );

    assign data_comb[8*i +: 8] = !byte_en[i] ? 8'h00 :
                                 (turnOff ? PIPEData[8*i +: 8] : step_byte);
  end

  assign lfsr16_end = g_byte[LANE_BYTES-1].l16_out;
  assign lfsr23_end = g_byte[LANE_BYTES-1].l23_out;

  assign eieos = (mode == SH_OS) && byte_en[1] &&
                 (PIPEData[7:0] == EIEOS_B0) && (PIPEData[15:8] == EIEOS_B1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr16_r    <= LFSR16_SEED;
      lfsr23_r    <= '0;
      seed_pend_r <= 1'b1;
    end else if (PIPEDataValid) begin
      lfsr16_r    <= lfsr16_end;
      lfsr23_r    <= eieos ? seedValue[22:0] : lfsr23_end;
      seed_pend_r <= 1'b0;
    end
  end

  // p0 -> p1: output register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      k_p1    <= '0;
      hdr_p1  <= '0;
    end else begin
      vld_p1  <= PIPEDataValid;
      data_p1 <= PIPEDataValid ? data_comb : '0;
      k_p1    <= PIPEDataK;
      hdr_p1  <= PIPESyncHeader;
    end
  end

  assign descramblerDataValid  = vld_p1;
  assign descramblerData       = data_p1;
  assign descramblerDataK      = k_p1;
  assign descramblerSyncHeader = hdr_p1;

endmodule

// File: tb/tb_descrambler.sv
// Directed scoreboard bench for the PIPE lane descrambler.
module tb_descrambler;

  localparam logic [23:0] SEED = 24'h8A5A5A;

  logic        clk;
  logic        reset;
  logic        turnOff;
  logic        PIPEDataValid;
  logic [5:0]  PIPEWIDTH;
  logic [1:0]  PIPESyncHeader;
  logic [23:0] seedValue;
  logic [31:0] PIPEData;
  logic [3:0]  PIPEDataK;
  logic        descramblerDataValid;
  logic [31:0] descramblerData;
  logic [3:0]  descramblerDataK;
  logic [1:0]  descramblerSyncHeader;

  descrambler dut (
    .clk                   (clk),
    .reset                 (reset),
    .turnOff               (turnOff),
    .PIPEDataValid         (PIPEDataValid),
    .PIPEWIDTH             (PIPEWIDTH),
    .PIPESyncHeader        (PIPESyncHeader),
    .seedValue             (seedValue),
    .PIPEData              (PIPEData),
    .PIPEDataK             (PIPEDataK),
    .descramblerDataValid  (descramblerDataValid),
    .descramblerData       (descramblerData),
    .descramblerDataK      (descramblerDataK),
    .descramblerSyncHeader (descramblerSyncHeader)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
    logic [3:0]  k;
    logic [1:0]  hdr;
  } exp_t;

  exp_t        sb[$];
  string       tq[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m16;
  logic [22:0] m23;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    assert (act === exp_v) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, act, exp_v);
    end
  endtask

  // Bit-serial reference: keystream bit is the LFSR MSB, feedback spelled out per tap
  task automatic model_word(input logic [5:0] w, input logic [1:0] h, input logic [31:0] d,
                            input logic [3:0] k, input logic toff, output logic [31:0] q);
    int         nb;
    logic [7:0] x;
    logic [7:0] y;
    logic       fb;
    nb = (w == 6'd8) ? 1 : ((w == 6'd16) ? 2 : 4);
    q  = '0;
    for (int b = 0; b < nb; b++) begin
      x = d[8*b +: 8];
      y = x;
      if (h == 2'b00) begin
        if (k[b] && x == 8'hBC) begin
          m16 = 16'hFFFF;
        end else if (!(k[b] && x == 8'h1C)) begin
          for (int i = 0; i < 8; i++) begin
            fb = m16[15];
            if (!k[b]) y[i] = x[i] ^ fb;
            m16 = {m16[14:5], m16[4] ^ fb, m16[3] ^ fb, m16[2] ^ fb, m16[1:0], fb};
          end
        end
      end else if (h == 2'b01) begin
        for (int i = 0; i < 8; i++) begin
          fb   = m23[22];
          y[i] = x[i] ^ fb;
          m23  = {m23[21], m23[20] ^ fb, m23[19:16], m23[15] ^ fb, m23[14:8], m23[7] ^ fb,
                  m23[6:5], m23[4] ^ fb, m23[3:2], m23[1] ^ fb, m23[0], fb};
        end
      end
      q[8*b +: 8] = toff ? x : y;
    end
    if (h == 2'b10 && nb >= 2 && d[15:0] == 16'hFF00) m23 = SEED[22:0];
  endtask

  task automatic collect();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tq.pop_front();
    check({t, " valid"}, 32'(descramblerDataValid), 32'(e.vld));
    check({t, " data"}, descramblerData, e.data);
    check({t, " k"}, 32'(descramblerDataK), 32'(e.k));
    check({t, " hdr"}, 32'(descramblerSyncHeader), 32'(e.hdr));
  endtask

  task automatic step(input string tag, input logic v, input logic [5:0] w, input logic [1:0] h,
                      input logic [31:0] d, input logic [3:0] k, input logic toff,
                      input logic fixed, input logic [31:0] fixed_exp);
    exp_t        e;
    logic [31:0] q;
    PIPEDataValid  = v;
    PIPEWIDTH      = w;
    PIPESyncHeader = h;
    PIPEData       = d;
    PIPEDataK      = k;
    turnOff        = toff;
    q = '0;
    if (v) model_word(w, h, d, k, toff, q);
    e.vld  = v;
    e.data = fixed ? fixed_exp : q;
    e.k    = k;
    e.hdr  = h;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    collect();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " valid"}, 32'(descramblerDataValid), 32'd0);
    check({tag, " data"}, descramblerData, 32'd0);
    check({tag, " k"}, 32'(descramblerDataK), 32'd0);
    check({tag, " hdr"}, 32'(descramblerSyncHeader), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    turnOff        = 1'b0;
    PIPEDataValid  = 1'b1;
    PIPEWIDTH      = 6'd32;
    PIPESyncHeader = 2'b01;
    seedValue      = SEED;
    PIPEData       = 32'hFFFFFFFF;
    PIPEDataK      = 4'hF;
    #1;
    reset_checks("rst_init");
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst_hold");

    reset = 1'b1;
    m16   = 16'hFFFF;
    m23   = SEED[22:0];

    // 8b/10b, full width, then continuation
    step("com32",  1'b1, 6'd32, 2'b00, 32'h000000BC, 4'b0001, 1'b0, 1'b1, 32'hC017FFBC);
    step("cont32", 1'b1, 6'd32, 2'b00, 32'h00000000, 4'b0000, 1'b0, 1'b1, 32'h02E7B214);

    // Byte-wide COM / SKP / data, upper input bytes must not leak
    step("com8",   1'b1, 6'd8, 2'b00, 32'hDEADBEBC, 4'b1111, 1'b0, 1'b1, 32'h000000BC);
    step("skp8",   1'b1, 6'd8, 2'b00, 32'h5A5A5A1C, 4'b0001, 1'b0, 1'b1, 32'h0000001C);
    step("dat8",   1'b1, 6'd8, 2'b00, 32'h77777700, 4'b0000, 1'b0, 1'b1, 32'h000000FF);
    step("dat8b",  1'b1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 1'b0, 1'b1, 32'h00000017);

    // Valid gap holds the LFSR
    for (int g = 0; g < 3; g++)
      step("gap",  1'b0, 6'd8, 2'b00, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 32'h0);
    step("resume", 1'b1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 1'b0, 1'b1, 32'h000000C0);

    // Bypass keeps the LFSR tracking
    step("toff_com", 1'b1, 6'd16, 2'b00, 32'hAA0055BC, 4'b0001, 1'b1, 1'b1, 32'h000055BC);
    step("toff_dat", 1'b1, 6'd16, 2'b00, 32'h0000A53C, 4'b0000, 1'b1, 1'b1, 32'h0000A53C);
    step("toff_off", 1'b1, 6'd16, 2'b00, 32'h00000000, 4'b0000, 1'b0, 1'b1, 32'h0000B214);
    step("w_other",  1'b1, 6'd40, 2'b00, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0);

    // 128b/130b: data from seed, EIEOS reload, other OS / invalid hold
    step("d130",      1'b1, 6'd32, 2'b01, 32'h12345678, 4'b0000, 1'b0, 1'b0, 32'h0);
    step("eieos",     1'b1, 6'd32, 2'b10, 32'hFF00FF00, 4'b0000, 1'b0, 1'b1, 32'hFF00FF00);
    step("d130_seed", 1'b1, 6'd32, 2'b01, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0);
    step("os_other",  1'b1, 6'd32, 2'b10, 32'h1C1C1C1C, 4'b0000, 1'b0, 1'b1, 32'h1C1C1C1C);
    step("hdr11",     1'b1, 6'd32, 2'b11, 32'hCAFEF00D, 4'b1010, 1'b0, 1'b1, 32'hCAFEF00D);
    step("d130_b",    1'b1, 6'd32, 2'b01, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0);
    step("mode00",    1'b1, 6'd32, 2'b00, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0);
    step("d130_toff", 1'b1, 6'd32, 2'b01, 32'h0F0F0F0F, 4'b0000, 1'b1, 1'b1, 32'h0F0F0F0F);
    step("d130_c",    1'b1, 6'd32, 2'b01, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-stream, with a COM presented while held
    PIPEData       = 32'h000000BC;
    PIPEDataK      = 4'b0001;
    PIPESyncHeader = 2'b00;
    PIPEDataValid  = 1'b1;
    reset          = 1'b0;
    #1;
    reset_checks("rst_async");
    @(posedge clk);
    #1;
    reset_checks("rst_com");
    reset = 1'b1;
    m16   = 16'hFFFF;
    m23   = SEED[22:0];
    step("post_rst", 1'b1, 6'd32, 2'b00, 32'h000000BC, 4'b0001, 1'b0, 1'b1, 32'hC017FFBC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
